wb_register_file: RTL and testbench
===================================

// Module: wb_register_file
// PURPOSE
// - Architectural register file and in-flight write scoreboard; it is the consuming end of the write-back path.
// - Write-back writes the selected result (memory data or ALU result) into it.
// - The ID stage reads two source operands from it and gets per-source hazard flags.
// - It tracks how many issued instructions still owe a write to each register, so the hazard unit stalls decode.
// PARAMETERS
// - DATA_W   32  register width
// - NUM_REGS 15  implemented registers, index 0..NUM_REGS-1
// - ADDR_W   4   register address width
// - CNT_W    2   per-register in-flight write counter width; max outstanding = 2**CNT_W-1
// PORTS
// - clk         in   1       clock, all state updates on rising edge
// - rst         in   1       synchronous, active-high reset
// - wb_en       in   1       write-back valid this cycle
// - wb_dest     in   ADDR_W  write-back destination register
// - wb_value    in   DATA_W  write-back data, already muxed memory/ALU result
// - issue_en    in   1       ID issues an instruction that will write issue_dest
// - issue_dest  in   ADDR_W  destination of the issuing instruction
// - src1        in   ADDR_W  operand 1 read address
// - src2        in   ADDR_W  operand 2 read address
// - src1_used   in   1       operand 1 is consumed; gates hazard1
// - src2_used   in   1       operand 2 is consumed; gates hazard2
// - reg1        out  DATA_W  operand 1 value, combinational read
// - reg2        out  DATA_W  operand 2 value, combinational read
// - hazard1     out  1       operand 1 has an outstanding write
// - hazard2     out  1       operand 2 has an outstanding write
// - sb_err      out  1       sticky scoreboard error, overflow or underflow
// BEHAVIOUR
// - Reset (rst=1 at posedge): all registers 0, all counters 0, sb_err 0.
// - Outputs that follow from reset: reg1/reg2 = 0; hazard1/hazard2 = 0.
// - Write: on posedge with wb_en=1 and wb_dest<NUM_REGS, regs[wb_dest] <= wb_value.
//   Writes to addresses >= NUM_REGS are discarded.
// - Read: combinational. Address >= NUM_REGS returns 0 with hazard 0.
// - Counter update for register r, per posedge:
//   inc = issue_en & issue_dest==r; dec = wb_en & wb_dest==r.
//   - inc only: cnt+1.
//   - dec only: cnt-1.
//   - inc and dec together: cnt unchanged.
// - Overflow: inc only with cnt at max -> cnt holds, sb_err <= 1.
// - Underflow: dec only with cnt==0 -> cnt stays 0, sb_err <= 1; the data write still happens.
// - sb_err clears only on rst.
// - hazardN = srcN_used & (cnt[srcN] != 0); the bypass macro modifies this (see CONFIGURATION).
//   hazardN depends on current counter state only; issue/wb in the same cycle affect it from the next cycle.
// - Latency:
//   - issue raises a hazard on the following cycle.
//   - A write is readable from the array the cycle after wb_en.
// - Reset mid-operation:
//   - rst has priority over wb_en and issue_en in the same cycle.
//   - All pending counts are dropped; the pipeline is flushed by the same reset.
// CONFIGURATION
// - Macro WB_RF_BYPASS_EN.
// - Defined:
//   - If wb_en & wb_dest==srcN (valid address), regN = wb_value in the same cycle.
//   - hazardN = srcN_used & (cnt[srcN] > 1) when write-back to srcN is active that cycle.
//   - hazardN = srcN_used & (cnt[srcN] != 0) otherwise.
// - Undefined:
//   - regN always reflects the stored array.
//   - A register being written back this cycle still reports hazard, giving a 1-cycle longer stall.
// STRUCTURE
// - Shared package/header: DATA_W, ADDR_W, NUM_REGS and CNT_W defaults.
// - Shared package/header: register index constants (SP, LR, PC-related indices used by decode).
// - One sub-module: wb_rf_scoreboard, holding the counter array, sb_err and hazard generation.
//   It is instantiated once; read-port muxing and the data array stay in the top.
// TESTING
// - After reset, read src1=3, src2=14 -> reg1=0, reg2=0, hazard1=0, hazard2=0, sb_err=0.
// - wb_en=1, wb_dest=5, wb_value=32'hDEADBEEF; next cycle src1=5 -> reg1=32'hDEADBEEF.
//   With bypass: same-cycle src1=5 already reads 32'hDEADBEEF.
// - issue_en dest=7 for two cycles -> cnt[7]=2, hazard1=1 for src1=7, src1_used=1.
//   First wb to 7 -> hazard1 stays 1.
//   Second wb to 7 -> hazard1=0 on the next cycle (bypass build: in the cycle of the second wb).
// - Same cycle issue_en dest=4 and wb_en dest=4 with cnt[4]=1 -> cnt stays 1, hazard persists, regs[4] updated.
// - cnt[2]=3, issue dest=2 -> sb_err=1, cnt holds 3.
//   Then wb_en dest=9 with cnt[9]=0 -> sb_err stays 1, regs[9] written.
// - Mid-test: cnt[6]=2 and hazard1=1, assert rst with simultaneous wb_en dest=6 value 1 -> regs[6]=0, hazard1=0, sb_err=0.
//   Write to address 15 -> no state change, read of 15 returns 0.

Source files
------------

// File: rtl/wb_register_file_pkg.sv
// rtl/wb_register_file_pkg.sv - widths, register indices and address helper for the write-back register file
package wb_register_file_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 15;
  localparam int ADDR_W   = 4;
  localparam int CNT_W    = 2;

  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [ADDR_W:0]   NUM_REGS_A  = (ADDR_W+1)'(NUM_REGS);

  // Architectural indices used by decode; PC sits above the implemented array.
  localparam logic [ADDR_W-1:0] REG_SP = 4'd13;
  localparam logic [ADDR_W-1:0] REG_LR = 4'd14;
  localparam logic [ADDR_W-1:0] REG_PC = 4'd15;

  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_A);
  endfunction

endpackage

// File: rtl/wb_register_file_if.sv
// rtl/wb_register_file_if.sv - write-back, issue and operand-read signals of the register file
interface wb_register_file_if;
  import wb_register_file_pkg::*;

  logic              wb_en;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_dest;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic              src1_used;
  logic              src2_used;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic              hazard1;
  logic              hazard2;
  logic              sb_err;

  modport master (
    output wb_en, wb_dest, wb_value, issue_en, issue_dest,
           src1, src2, src1_used, src2_used,
    input  reg1, reg2, hazard1, hazard2, sb_err
  );

  modport slave (
    input  wb_en, wb_dest, wb_value, issue_en, issue_dest,
           src1, src2, src1_used, src2_used,
    output reg1, reg2, hazard1, hazard2, sb_err
  );

endinterface

// File: rtl/wb_rf_scoreboard.sv
// rtl/wb_rf_scoreboard.sv - per-register in-flight write counters, sticky error and hazard flags (WB_RF_BYPASS_EN)
module wb_rf_scoreboard
  import wb_register_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic              src1_used,
  input  logic              src2_used,
  output logic              hazard1,
  output logic              hazard2,
  output logic              sb_err
);

  logic [CNT_W-1:0]    cnt      [NUM_REGS];
  logic [CNT_W-1:0]    cnt_next [NUM_REGS];
  logic [NUM_REGS-1:0] inc_hit;
  logic [NUM_REGS-1:0] dec_hit;
  logic                err_now;
  logic [CNT_W-1:0]    pend1;
  logic [CNT_W-1:0]    pend2;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    err_now = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_hit[r]  = issue_en && (issue_dest == r[ADDR_W-1:0]);
      dec_hit[r]  = wb_en && (wb_dest == r[ADDR_W-1:0]);
      cnt_next[r] = cnt[r];
      // Saturate at both ends and flag it; simultaneous inc/dec cancel out.
      if (inc_hit[r] && !dec_hit[r]) begin
        if (cnt[r] == CNT_MAX) err_now = 1'b1;
        else                   cnt_next[r] = cnt[r] + CNT_W'(1);
      end else if (dec_hit[r] && !inc_hit[r]) begin
        if (cnt[r] == '0) err_now = 1'b1;
        else              cnt_next[r] = cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_next[r];
      sb_err <= sb_err | err_now;
    end
  end

  always_comb begin
    pend1 = '0;
    pend2 = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (src1 == r[ADDR_W-1:0]) pend1 = cnt[r];
      if (src2 == r[ADDR_W-1:0]) pend2 = cnt[r];
    end
`ifdef WB_RF_BYPASS_EN
    // The write retiring this cycle is forwarded, so it no longer blocks the reader.
    hazard1 = src1_used && ((wb_en && wb_dest == src1) ? (pend1 > CNT_W'(1)) : (pend1 != '0));
    hazard2 = src2_used && ((wb_en && wb_dest == src2) ? (pend2 > CNT_W'(1)) : (pend2 != '0));
`else
    hazard1 = src1_used && (pend1 != '0);
    hazard2 = src2_used && (pend2 != '0);
`endif
  end

endmodule

// File: rtl/wb_register_file.sv
// rtl/wb_register_file.sv - register file with write-back port, two read ports and write scoreboard (WB_RF_BYPASS_EN)
module wb_register_file
  import wb_register_file_pkg::*;
(
  input logic               clk,
  input logic               rst,
  wb_register_file_if.slave bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  // Address NUM_REGS and above never matches an entry, so such writes fall away.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (bus.wb_en && bus.wb_dest == i[ADDR_W-1:0]) regs[i] <= bus.wb_value;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.src1 == i[ADDR_W-1:0]) rd1 = regs[i];
      if (bus.src2 == i[ADDR_W-1:0]) rd2 = regs[i];
    end
`ifdef WB_RF_BYPASS_EN
    if (bus.wb_en && addr_valid(bus.wb_dest)) begin
      if (bus.src1 == bus.wb_dest) rd1 = bus.wb_value;
      if (bus.src2 == bus.wb_dest) rd2 = bus.wb_value;
    end
`endif
  end

  assign bus.reg1 = rd1;
  assign bus.reg2 = rd2;

  wb_rf_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (bus.issue_en),
    .issue_dest (bus.issue_dest),
    .wb_en      (bus.wb_en),
    .wb_dest    (bus.wb_dest),
    .src1       (bus.src1),
    .src2       (bus.src2),
    .src1_used  (bus.src1_used),
    .src2_used  (bus.src2_used),
    .hazard1    (bus.hazard1),
    .hazard2    (bus.hazard2),
    .sb_err     (bus.sb_err)
  );

endmodule

// File: tb/tb_wb_register_file.sv
// tb/tb_wb_register_file.sv - directed vector table plus randomized run against a reference model
module tb_wb_register_file;

`ifdef WB_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    bit          rst;
    bit          we;
    logic [3:0]  wd;
    logic [31:0] wv;
    bit          ie;
    logic [3:0]  id;
    logic [3:0]  s1;
    logic [3:0]  s2;
    bit          u1;
    bit          u2;
    bit          chk;
    logic [31:0] r1;
    logic [31:0] r2;
    bit          h1;
    bit          h2;
    bit          er;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  int   m_reg [16];
  int   m_cnt [16];
  bit   m_err;

  always #5 clk = ~clk;

  wb_register_file_if bus ();

  wb_register_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t mk(bit r, bit we, logic [3:0] wd, logic [31:0] wv, bit ie, logic [3:0] id,
                              logic [3:0] s1, logic [3:0] s2, bit u1, bit u2, bit chk,
                              logic [31:0] r1, logic [31:0] r2, bit h1, bit h2, bit er);
    vec_t v;
    v.rst = r; v.we = we; v.wd = wd; v.wv = wv; v.ie = ie; v.id = id;
    v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2; v.chk = chk;
    v.r1 = r1; v.r2 = r2; v.h1 = h1; v.h2 = h2; v.er = er;
    return v;
  endfunction

  function automatic logic [31:0] exp_read(vec_t v, logic [3:0] a);
    if (a >= 15) return 32'd0;
    if (BYP && v.we && v.wd == a) return v.wv;
    return m_reg[a];
  endfunction

  // Pending writes on a register; with forwarding, the one retiring now no longer counts.
  function automatic bit exp_hazard(vec_t v, logic [3:0] a, bit used);
    int pend;
    if (!used || a >= 15) return 1'b0;
    pend = m_cnt[a];
    if (BYP && v.we && v.wd == a) pend = pend - 1;
    return pend > 0;
  endfunction

  function automatic void model_step(vec_t v);
    int net;
    if (v.rst) begin
      for (int i = 0; i < 16; i++) begin m_reg[i] = 0; m_cnt[i] = 0; end
      m_err = 1'b0;
      return;
    end
    if (v.we && v.wd < 15) m_reg[v.wd] = v.wv;
    for (int r = 0; r < 15; r++) begin
      net = 0;
      if (v.ie && v.id == r) net = net + 1;
      if (v.we && v.wd == r) net = net - 1;
      m_cnt[r] = m_cnt[r] + net;
      if (m_cnt[r] < 0) begin m_cnt[r] = 0; m_err = 1'b1; end
      if (m_cnt[r] > 3) begin m_cnt[r] = 3; m_err = 1'b1; end
    end
  endfunction

  task automatic apply(input vec_t v, input bit use_model, input string name);
    rst = v.rst;
    bus.wb_en = v.we; bus.wb_dest = v.wd; bus.wb_value = v.wv;
    bus.issue_en = v.ie; bus.issue_dest = v.id;
    bus.src1 = v.s1; bus.src2 = v.s2; bus.src1_used = v.u1; bus.src2_used = v.u2;
    @(negedge clk);
    if (use_model) begin
      v.r1 = exp_read(v, v.s1);
      v.r2 = exp_read(v, v.s2);
      v.h1 = exp_hazard(v, v.s1, v.u1);
      v.h2 = exp_hazard(v, v.s2, v.u2);
      v.er = m_err;
    end
    if (v.chk) begin
      vectors++;
      if (bus.reg1 !== v.r1 || bus.reg2 !== v.r2 || bus.hazard1 !== v.h1 ||
          bus.hazard2 !== v.h2 || bus.sb_err !== v.er) begin
        miscompares++;
        $display("FAIL %s: got reg1=%h reg2=%h hz1=%b hz2=%b err=%b, want reg1=%h reg2=%h hz1=%b hz2=%b err=%b",
                 name, bus.reg1, bus.reg2, bus.hazard1, bus.hazard2, bus.sb_err,
                 v.r1, v.r2, v.h1, v.h2, v.er);
      end
    end
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  vec_t tbl [29];

  initial begin
    vec_t       rv;
    logic [3:0] d;
    rst = 1'b1;
    bus.wb_en = 1'b0; bus.wb_dest = '0; bus.wb_value = '0;
    bus.issue_en = 1'b0; bus.issue_dest = '0;
    bus.src1 = '0; bus.src2 = '0; bus.src1_used = 1'b0; bus.src2_used = 1'b0;

    //              rst we wd  wv            ie id  s1  s2  u1 u2 chk r1                            r2                           h1          h2 er
    tbl[0]  = mk(1, 0, 0,  32'h0,         0, 0,  0,  0,  0, 0, 0, 32'h0,                        32'h0,                       0,          0, 0);
    tbl[1]  = mk(0, 0, 0,  32'h0,         0, 0,  3,  14, 1, 1, 1, 32'h0,                        32'h0,                       0,          0, 0);
    tbl[2]  = mk(0, 0, 0,  32'h0,         1, 5,  5,  0,  1, 0, 1, 32'h0,                        32'h0,                       0,          0, 0);
    tbl[3]  = mk(0, 1, 5,  32'hDEADBEEF,  0, 0,  5,  0,  1, 0, 1, BYP ? 32'hDEADBEEF : 32'h0,   32'h0,                       !BYP,       0, 0);
    tbl[4]  = mk(0, 0, 0,  32'h0,         0, 0,  5,  0,  1, 0, 1, 32'hDEADBEEF,                 32'h0,                       0,          0, 0);
    tbl[5]  = mk(0, 0, 0,  32'h0,         1, 7,  7,  0,  1, 0, 1, 32'h0,                        32'h0,                       0,          0, 0);
    tbl[6]  = mk(0, 0, 0,  32'h0,         1, 7,  7,  0,  1, 0, 1, 32'h0,                        32'h0,                       1,          0, 0);
    tbl[7]  = mk(0, 0, 0,  32'h0,         0, 0,  7,  0,  1, 0, 1, 32'h0,                        32'h0,                       1,          0, 0);
    tbl[8]  = mk(0, 1, 7,  32'h11,        0, 0,  7,  0,  1, 0, 1, BYP ? 32'h11 : 32'h0,         32'h0,                       1,          0, 0);
    tbl[9]  = mk(0, 1, 7,  32'h22,        0, 0,  7,  0,  1, 0, 1, BYP ? 32'h22 : 32'h11,        32'h0,                       !BYP,       0, 0);
    tbl[10] = mk(0, 0, 0,  32'h0,         0, 0,  7,  0,  1, 0, 1, 32'h22,                       32'h0,                       0,          0, 0);
    tbl[11] = mk(0, 0, 0,  32'h0,         1, 4,  4,  0,  1, 0, 1, 32'h0,                        32'h0,                       0,          0, 0);
    tbl[12] = mk(0, 1, 4,  32'h44,        1, 4,  4,  0,  1, 0, 1, BYP ? 32'h44 : 32'h0,         32'h0,                       !BYP,       0, 0);
    tbl[13] = mk(0, 0, 0,  32'h0,         0, 0,  4,  0,  1, 0, 1, 32'h44,                       32'h0,                       1,          0, 0);
    tbl[14] = mk(0, 0, 0,  32'h0,         1, 2,  0,  2,  0, 1, 1, 32'h0,                        32'h0,                       0,          0, 0);
    tbl[15] = mk(0, 0, 0,  32'h0,         1, 2,  0,  2,  0, 1, 1, 32'h0,                        32'h0,                       0,          1, 0);
    tbl[16] = mk(0, 0, 0,  32'h0,         1, 2,  0,  2,  0, 1, 1, 32'h0,                        32'h0,                       0,          1, 0);
    tbl[17] = mk(0, 0, 0,  32'h0,         1, 2,  0,  2,  0, 1, 1, 32'h0,                        32'h0,                       0,          1, 0);
    tbl[18] = mk(0, 1, 9,  32'h99,        0, 0,  9,  2,  1, 1, 1, BYP ? 32'h99 : 32'h0,         32'h0,                       0,          1, 1);
    tbl[19] = mk(0, 0, 0,  32'h0,         0, 0,  9,  2,  1, 1, 1, 32'h99,                       32'h0,                       0,          1, 1);
    tbl[20] = mk(0, 1, 2,  32'h202,       0, 0,  0,  2,  0, 1, 1, 32'h0,                        BYP ? 32'h202 : 32'h0,       0,          1, 1);
    tbl[21] = mk(0, 1, 2,  32'h203,       0, 0,  0,  2,  0, 1, 1, 32'h0,                        BYP ? 32'h203 : 32'h202,     0,          1, 1);
    tbl[22] = mk(0, 0, 0,  32'h0,         0, 0,  2,  2,  0, 1, 1, 32'h203,                      32'h203,                     0,          1, 1);
    tbl[23] = mk(0, 0, 0,  32'h0,         1, 6,  6,  0,  1, 0, 1, 32'h0,                        32'h0,                       0,          0, 1);
    tbl[24] = mk(0, 0, 0,  32'h0,         1, 6,  6,  0,  1, 0, 1, 32'h0,                        32'h0,                       1,          0, 1);
    tbl[25] = mk(1, 1, 6,  32'h1,         0, 0,  6,  0,  1, 0, 1, BYP ? 32'h1 : 32'h0,          32'h0,                       1,          0, 1);
    tbl[26] = mk(0, 0, 0,  32'h0,         0, 0,  6,  9,  1, 1, 1, 32'h0,                        32'h0,                       0,          0, 0);
    tbl[27] = mk(0, 1, 15, 32'hFFFFFFFF,  0, 0,  15, 15, 1, 1, 1, 32'h0,                        32'h0,                       0,          0, 0);
    tbl[28] = mk(0, 0, 0,  32'h0,         0, 0,  15, 0,  1, 0, 1, 32'h0,                        32'h0,                       0,          0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 29; i++) apply(tbl[i], 1'b0, $sformatf("tbl%0d", i));

    // Randomized phase: the opening reset syncs the model with the DUT.
    rv = mk(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    apply(rv, 1'b1, "rand_reset");
    for (int n = 0; n < 800; n++) begin
      rv.rst = ($urandom_range(0, 99) == 0);
      rv.we  = $urandom_range(0, 1);
      d = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      rv.wd  = d;
      rv.wv  = $urandom;
      rv.ie  = $urandom_range(0, 1);
      d = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      rv.id  = d;
      d = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      rv.s1  = d;
      d = ($urandom_range(0, 7) == 0) ? 4'd14 : 4'($urandom_range(0, 5));
      rv.s2  = d;
      rv.u1  = $urandom_range(0, 1);
      rv.u2  = $urandom_range(0, 1);
      rv.chk = 1'b1;
      apply(rv, 1'b1, $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
